// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider-sharing controller.
`timescale 1ns/1ps
package div_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Quotient reported on divide-by-zero, sliced down to the operand width.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_share_ctrl_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr+1, pointer moves on accept.
`timescale 1ns/1ps
module rr_arbiter
    import div_share_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = idw(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] rr_ptr;
    logic           found;

    // Walk the requesters starting just after the last winner and keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (((int'(rr_ptr) + i) % NREQ) == j)) begin
                    grant[j]  = 1'b1;
                    grant_idx = IDW'(j);
                    found     = 1'b1;
                end
            end
        end
    end

    // Resetting to the last index gives requester 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IDW'(NREQ - 1);
        end else if (accept) begin
            rr_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider among NREQ requesters with round-robin arbitration,
// divide-by-zero bypass and a completion watchdog.
`timescale 1ns/1ps
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int WID  = 8,
    parameter int NREQ = 4,
    parameter int TMO  = 4*WID + 8,
    localparam int IDW = idw(NREQ),
    localparam int WDW = $clog2(TMO + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*WID-1:0] req_dividend,
    input  logic [NREQ*WID-1:0] req_divisor,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [WID-1:0]      resp_quotient,
    output logic [WID-1:0]      resp_remainder,
    output logic                resp_dbz,
    output logic                resp_err,
    output logic                div_valid,
    output logic [WID-1:0]      div_dividend,
    output logic [WID-1:0]      div_divisor,
    input  logic                div_ready,
    input  logic [WID-1:0]      div_quotient,
    input  logic [WID-1:0]      div_remainder
);

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           timeout;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_idx;
    logic [WID-1:0] sel_dividend;
    logic [WID-1:0] sel_divisor;
    logic [WDW-1:0] wd_count;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The reset term keeps req_ready low while reset is held with requests pending.
    assign accept  = (state == IDLE) && (|req_valid) && !rst;
    assign timeout = (wd_count == WDW'(TMO - 1));

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_dividend = req_dividend[i*WID +: WID];
                sel_divisor  = req_divisor[i*WID +: WID];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        div_valid  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    req_ready  = grant;
                    state_next = (sel_divisor == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_valid  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (div_ready || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts WAIT cycles; TMO cycles in WAIT without a completion is a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_count <= '0;
        end else if (state == ISSUE) begin
            wd_count <= '0;
        end else if ((state == WAIT) && !timeout) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    // A completion arriving on the expiry cycle is still taken as a good result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_dividend   <= '0;
            div_divisor    <= '0;
            resp_id        <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_dbz       <= 1'b0;
            resp_err       <= 1'b0;
        end else begin
            if (accept) begin
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
                resp_id      <= grant_idx;
                resp_err     <= 1'b0;
                if (sel_divisor == '0) begin
                    resp_quotient  <= DBZ_QUOTIENT[WID-1:0];
                    resp_remainder <= sel_dividend;
                    resp_dbz       <= 1'b1;
                end else begin
                    resp_dbz <= 1'b0;
                end
            end
            if (state == WAIT) begin
                if (div_ready) begin
                    resp_quotient  <= div_quotient;
                    resp_remainder <= div_remainder;
                    resp_dbz       <= 1'b0;
                    resp_err       <= 1'b0;
                end else if (timeout) begin
                    resp_quotient  <= '0;
                    resp_remainder <= '0;
                    resp_dbz       <= 1'b0;
                    resp_err       <= 1'b1;
                end
            end
        end
    end

endmodule
